// File: rtl/noc_tok_pkg.sv
// Shared types, widths and the round-robin pick helper for the NoC token
// link arbiter.
package noc_tok_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } tok_state_e;

  localparam int TOK0_DATA_W = 42;
  localparam int TOK1_DATA_W = 32;

  // Widest requester vector the pick helper handles.
  localparam int MAX_REQ = 8;

  // One-hot grant: first set bit of req searching upward from ptr, wrapping
  // at num. Wrap uses a compare so non-power-of-2 counts stay correct.
  function automatic logic [MAX_REQ-1:0] rr_pick(
    input logic [MAX_REQ-1:0] req,
    input logic [2:0]         ptr,
    input int                 num
  );
    logic [MAX_REQ-1:0] grant;
    logic               found;
    int                 idx;
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      if (k < num) begin
        idx = int'(ptr) + k;
        if (idx >= num) idx = idx - num;
        if (!found && req[idx]) begin
          grant[idx] = 1'b1;
          found      = 1'b1;
        end
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/noc_tok_out_reg.sv
// Single vld/rdy register slice carrying flit data, head and tail to the link.
module noc_tok_out_reg
  import noc_tok_pkg::*;
#(
  parameter int DATA_W = TOK0_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_head,
  input  logic              in_tail,
  input  logic              lnk_rdy,
  output logic              slot_free,
  output logic              out_vld,
  output logic [DATA_W-1:0] out_data,
  output logic              out_head,
  output logic              out_tail
);

  // The slot can take a new beat when empty or when its beat leaves this cycle.
  assign slot_free = !out_vld || lnk_rdy;

  // Capture a beat on load; otherwise drain the slot once the link takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the data register is reset as well, because every egress output
      // must read 0 while reset is held, not just the valid bit.
      out_vld  <= 1'b0;
      out_data <= '0;
      out_head <= 1'b0;
      out_tail <= 1'b0;
    end else if (load) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      out_vld  <= 1'b1;
      out_data <= in_data;
      out_head <= in_head;
      out_tail <= in_tail;
    end else if (lnk_rdy) begin
      out_vld <= 1'b0;
    end
  end

endmodule

// File: rtl/noc_tok_lnk_arb.sv
// Packet-atomic round-robin arbiter merging NUM_REQ token streams onto one
// NoC token cross-link egress. A head win locks the link to that requester
// until its tail beat is accepted.
module noc_tok_lnk_arb
  import noc_tok_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = TOK0_DATA_W,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                      i_noc_clk,
  input  logic                      i_noc_rst_n,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
  input  logic [NUM_REQ-1:0]        i_req_head,
  input  logic [NUM_REQ-1:0]        i_req_tail,
  input  logic [NUM_REQ-1:0]        i_req_vld,
  output logic [NUM_REQ-1:0]        o_req_rdy,
  output logic [DATA_W-1:0]         o_lnk_data,
  output logic                      o_lnk_head,
  output logic                      o_lnk_tail,
  output logic                      o_lnk_vld,
  input  logic                      i_lnk_rdy,
  output logic [IDX_W-1:0]          o_grant_idx,
  output logic                      o_locked,
  output logic                      o_proto_err
);

  tok_state_e         state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]   pick_idx, pick_next, sel_idx;
  logic [MAX_REQ-1:0] pick;
  logic [NUM_REQ-1:0] cand, rdy;
  logic               slot_free, load, proto;

  assign cand = i_req_vld & i_req_head;
  assign pick = rr_pick(MAX_REQ'(cand), 3'(rr_ptr_q), NUM_REQ);

  // Convert the one-hot pick to an index and its wrapped successor.
  always_comb begin
    pick_idx = '0;
    for (int r = 0; r < MAX_REQ; r++) begin
      if (pick[r]) pick_idx = IDX_W'(r);
    end
    pick_next = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
  end

  // Next-state, grant selection and per-requester ready.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    sel_idx  = grant_q;
    rdy      = '0;
    proto    = 1'b0;
    case (state_q)
      IDLE: begin
        proto = |(i_req_vld & ~i_req_head);
        if (|cand && slot_free) begin
          rdy      = pick[NUM_REQ-1:0];
          sel_idx  = pick_idx;
          grant_d  = pick_idx;
          rr_ptr_d = pick_next;
          if (!i_req_tail[pick_idx]) state_d = LOCKED;
        end
      end
      LOCKED: begin
        rdy[grant_q] = slot_free;
        if (slot_free && i_req_vld[grant_q] && i_req_tail[grant_q]) state_d = IDLE;
      end
    endcase
  end

  // FSM, round-robin pointer and owner index registers.
  always_ff @(posedge i_noc_clk or negedge i_noc_rst_n) begin
    if (!i_noc_rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
    end
  end

  assign load = |(rdy & i_req_vld);

  noc_tok_out_reg #(.DATA_W(DATA_W)) u_out_reg (
    .clk       (i_noc_clk),
    .rst_n     (i_noc_rst_n),
    .load      (load),
    .in_data   (i_req_data[int'(sel_idx)*DATA_W +: DATA_W]),
    .in_head   (i_req_head[sel_idx]),
    .in_tail   (i_req_tail[sel_idx]),
    .lnk_rdy   (i_lnk_rdy),
    .slot_free (slot_free),
    .out_vld   (o_lnk_vld),
    .out_data  (o_lnk_data),
    .out_head  (o_lnk_head),
    .out_tail  (o_lnk_tail)
  );

  // Handshake outputs are combinational from requester inputs; hold them low
  // while reset is asserted so nothing is offered or flagged during reset.
  assign o_req_rdy   = rdy & {NUM_REQ{i_noc_rst_n}};
  assign o_proto_err = proto & i_noc_rst_n;
  assign o_grant_idx = grant_q;
  assign o_locked    = (state_q == LOCKED);

endmodule

// File: tb/tb_noc_tok_lnk_arb.sv
// Self-checking bench for noc_tok_lnk_arb: packet sources per requester, a
// behavioural arbiter model checked every cycle, and directed scenarios with
// hand-computed egress orders.
module tb_noc_tok_lnk_arb;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 42;
  localparam int IDX_W   = 2;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b1;
  logic [NUM_REQ*DATA_W-1:0] req_data = '0;
  logic [NUM_REQ-1:0]        req_head = '0, req_tail = '0, req_vld = '0, req_rdy;
  logic [DATA_W-1:0]         lnk_data;
  logic                      lnk_head, lnk_tail, lnk_vld;
  logic                      lnk_rdy = 1'b1;
  logic [IDX_W-1:0]          grant_idx;
  logic                      locked, proto_err;

  always #5 clk = ~clk;

  noc_tok_lnk_arb #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) dut (
    .i_noc_clk   (clk),
    .i_noc_rst_n (rst_n),
    .i_req_data  (req_data),
    .i_req_head  (req_head),
    .i_req_tail  (req_tail),
    .i_req_vld   (req_vld),
    .o_req_rdy   (req_rdy),
    .o_lnk_data  (lnk_data),
    .o_lnk_head  (lnk_head),
    .o_lnk_tail  (lnk_tail),
    .o_lnk_vld   (lnk_vld),
    .i_lnk_rdy   (lnk_rdy),
    .o_grant_idx (grant_idx),
    .o_locked    (locked),
    .o_proto_err (proto_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- sources: queued packet lengths per requester ----------
  int                 src_q[NUM_REQ][$];
  int                 bcnt[NUM_REQ];
  int                 seq[NUM_REQ];
  logic [NUM_REQ-1:0] bad = '0;
  logic               nxt_rst_n = 1'b0;
  logic               nxt_lnk_rdy = 1'b1;
  logic [NUM_REQ-1:0] acc = '0;
  int                 cyc = 0;

  typedef struct {
    int   id;
    int   sq;
    logic head;
    logic tail;
    int   cyc;
  } beat_t;
  beat_t eg_q[$];

  // Flit data carries requester id in [14:12] and [38:36], beat sequence in [11:0].
  task automatic drive();
    rst_n   = nxt_rst_n;
    lnk_rdy = nxt_lnk_rdy;
    for (int r = 0; r < NUM_REQ; r++) begin
      req_data[r*DATA_W +: DATA_W] = DATA_W'((longint'(r) << 36) | (longint'(r) << 12) | longint'(seq[r]));
      if (bad[r]) begin
        req_vld[r] = 1'b1; req_head[r] = 1'b0; req_tail[r] = 1'b0;
      end else if (src_q[r].size() != 0) begin
        req_vld[r]  = 1'b1;
        req_head[r] = (bcnt[r] == 0);
        req_tail[r] = (bcnt[r] == src_q[r][0] - 1);
      end else begin
        req_vld[r] = 1'b0; req_head[r] = 1'b0; req_tail[r] = 1'b0;
      end
    end
  endtask

  // One clock: drive after negedge, observe just before the posedge.
  task automatic cycle();
    @(negedge clk);
    drive();
    #3;
    acc = req_vld & req_rdy;
    if (lnk_vld && lnk_rdy)
      eg_q.push_back('{int'(lnk_data[14:12]), int'(lnk_data[11:0]), lnk_head, lnk_tail, cyc});
    for (int r = 0; r < NUM_REQ; r++) begin
      if (acc[r] && src_q[r].size() != 0) begin
        seq[r]++;
        bcnt[r]++;
        if (bcnt[r] == src_q[r][0]) begin
          bcnt[r] = 0;
          void'(src_q[r].pop_front());
        end
      end
    end
    cyc++;
  endtask

  function automatic logic idle_now();
    logic e;
    e = 1'b1;
    for (int r = 0; r < NUM_REQ; r++) if (src_q[r].size() != 0) e = 1'b0;
    return e && !lnk_vld && (acc == '0) && (bad == '0);
  endfunction

  task automatic run_until_idle(input string name, input int budget);
    int n;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!idle_now() && n < budget);
    check(name, idle_now(), 1'b1);
  endtask

  // ---------------- behavioural model of the arbiter ----------------------
  logic              m_locked = 1'b0, m_vld = 1'b0, m_head = 1'b0, m_tail = 1'b0;
  logic [DATA_W-1:0] m_data = '0;
  int                m_owner = 0, m_ptr = 0;
  logic [NUM_REQ-1:0] m_take;
  int                m_w;

  // Who the arbiter must offer ready to this cycle.
  function automatic logic [NUM_REQ-1:0] m_rdy();
    logic [NUM_REQ-1:0] g;
    g = '0;
    if (!rst_n) return g;
    if (m_vld && !lnk_rdy) return g;
    if (m_locked) begin
      g[m_owner] = 1'b1;
      return g;
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      int r;
      r = (m_ptr + k) % NUM_REQ;
      if (req_vld[r] && req_head[r]) begin
        g[r] = 1'b1;
        return g;
      end
    end
    return g;
  endfunction

  always_comb begin
    m_take = m_rdy() & req_vld;
    m_w = 0;
    for (int r = 0; r < NUM_REQ; r++) if (m_take[r]) m_w = r;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_locked <= 1'b0; m_vld <= 1'b0; m_head <= 1'b0; m_tail <= 1'b0;
      m_data <= '0; m_owner <= 0; m_ptr <= 0;
    end else if (m_take != '0) begin
      m_vld  <= 1'b1;
      m_data <= req_data[m_w*DATA_W +: DATA_W];
      m_head <= req_head[m_w];
      m_tail <= req_tail[m_w];
      if (!m_locked) begin
        m_owner  <= m_w;
        m_ptr    <= (m_w + 1) % NUM_REQ;
        m_locked <= !req_tail[m_w];
      end else if (req_tail[m_w]) begin
        m_locked <= 1'b0;
      end
    end else if (lnk_rdy) begin
      m_vld <= 1'b0;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    #2;
    check("cyc_req_rdy", req_rdy, m_rdy());
    check("cyc_proto_err", proto_err, rst_n && !m_locked && |(req_vld & ~req_head));
    check("cyc_locked", locked, m_locked);
    check("cyc_grant_idx", grant_idx, m_owner);
    check("cyc_lnk_vld", lnk_vld, m_vld);
    if (m_vld) begin
      check("cyc_lnk_data", lnk_data, m_data);
      check("cyc_lnk_head", lnk_head, m_head);
      check("cyc_lnk_tail", lnk_tail, m_tail);
    end
  end

  // ---------------- directed scenarios ------------------------------------
  int          exp_id[5]   = '{1, 1, 1, 2, 0};
  logic [4:0]  exp_head    = 5'b11001;  // bit i = beat i
  logic [4:0]  exp_tail    = 5'b11100;
  int          s0, n;
  logic [DATA_W-1:0] held;

  initial begin
    for (int r = 0; r < NUM_REQ; r++) begin bcnt[r] = 0; seq[r] = 0; end
    #1 rst_n = 1'b0;

    // Reset held with every requester presenting a head.
    for (int r = 0; r < NUM_REQ; r++) repeat (3) src_q[r].push_back(1);
    repeat (3) cycle();
    check("rst_req_rdy", req_rdy, 0);
    check("rst_lnk_vld", lnk_vld, 0);
    check("rst_lnk_data", lnk_data, 0);
    check("rst_lnk_head_tail", {lnk_head, lnk_tail}, 0);
    check("rst_grant_idx", grant_idx, 0);
    check("rst_locked", locked, 0);
    check("rst_proto_err", proto_err, 0);

    // Release: first grant to req0, then fair 0,1,2,3 rotation at full rate.
    nxt_rst_n = 1'b1;
    cycle();
    check("rst_first_grant", acc, 4'b0001);
    run_until_idle("fair_drain", 40);
    check("fair_count", eg_q.size(), 12);
    for (int i = 0; i < eg_q.size() && i < 12; i++) begin
      check("fair_order", eg_q[i].id, i % 4);
      if (i > 0) check("fair_no_gap", eg_q[i].cyc - eg_q[i-1].cyc, 1);
    end
    eg_q.delete();

    // Atomicity: req1 3-beat packet wins, then req2 and req0 wait their turn.
    src_q[1].push_back(3);
    cycle();
    check("atom_first_grant", acc, 4'b0010);
    src_q[0].push_back(1);
    src_q[2].push_back(1);
    run_until_idle("atom_drain", 40);
    check("atom_count", eg_q.size(), 5);
    for (int i = 0; i < eg_q.size() && i < 5; i++) begin
      check("atom_order", eg_q[i].id, exp_id[i]);
      check("atom_head", eg_q[i].head, exp_head[i]);
      check("atom_tail", eg_q[i].tail, exp_tail[i]);
      if (i > 0 && i < 3) check("atom_contig", eg_q[i].cyc - eg_q[i-1].cyc, 1);
    end
    eg_q.delete();

    // Backpressure: stall the link for 5 cycles after two beats of req3.
    s0 = seq[3];
    src_q[3].push_back(4);
    n = 0;
    while (seq[3] - s0 < 2 && n < 20) begin cycle(); n++; end
    check("bp_reach_stall", seq[3] - s0, 2);
    nxt_lnk_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      if (i == 0) begin
        held = lnk_data;
        check("bp_held_beat", {lnk_data[14:12], lnk_data[11:0]}, {3'd3, 12'(s0 + 1)});
      end else begin
        check("bp_data_stable", lnk_data, held);
      end
      check("bp_all_rdy_low", req_rdy, 0);
      check("bp_vld_held", lnk_vld, 1'b1);
    end
    nxt_lnk_rdy = 1'b1;
    run_until_idle("bp_drain", 40);
    check("bp_count", eg_q.size(), 4);
    for (int i = 0; i < eg_q.size() && i < 4; i++) begin
      check("bp_id", eg_q[i].id, 3);
      check("bp_seq", eg_q[i].sq, s0 + i);
      check("bp_head_tail", {eg_q[i].head, eg_q[i].tail}, {i == 0, i == 3});
    end
    eg_q.delete();

    // Protocol error: req3 offers a non-head beat while idle.
    bad[3] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("perr_pulse", proto_err, 1'b1);
      check("perr_rdy3_low", req_rdy[3], 1'b0);
      check("perr_no_egress", lnk_vld, 1'b0);
    end
    bad[3] = 1'b0;
    cycle();
    check("perr_clear", proto_err, 1'b0);

    // Reset mid-packet: after req1's head of a 4-beat packet.
    src_q[1].push_back(4);
    n = 0;
    do begin cycle(); n++; end while (acc[1] !== 1'b1 && n < 10);
    check("mid_head_taken", acc, 4'b0010);
    cycle();
    check("mid_locked_before", locked, 1'b1);
    nxt_rst_n = 1'b0;
    cycle();
    check("mid_rst_locked", locked, 1'b0);
    check("mid_rst_vld", lnk_vld, 1'b0);
    check("mid_rst_rdy", req_rdy, 0);
    check("mid_rst_grant", grant_idx, 0);
    src_q[1].delete();
    bcnt[1] = 0;
    nxt_rst_n = 1'b1;
    src_q[2].push_back(1);
    cycle();
    check("mid_new_grant", acc, 4'b0100);
    cycle();
    check("mid_new_egress", {lnk_vld, lnk_head, lnk_tail, lnk_data[14:12]}, {3'b111, 3'd2});
    check("mid_new_grant_idx", grant_idx, 2);
    run_until_idle("final_drain", 20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "time limit");
  end

endmodule
